// File: rtl/mic_sample_fifo_if.sv
// Sample FIFO bus bundle: SPI capture side in, bus reader side.
// slave = FIFO, master = producer/reader driving the strobes.
interface mic_sample_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  async_write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  sync_read;
  logic                  sync_enable;
  logic                  clear_flags;
  logic [DATA_WIDTH-1:0] data_out;
  logic [LW-1:0]         level;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic                  interrupt;

  modport master (
    output async_write, data_in, sync_read,
    output sync_enable, clear_flags,
    input  data_out, level, empty, full,
    input  overflow, underflow, interrupt
  );

  modport slave (
    input  async_write, data_in, sync_read,
    input  sync_enable, clear_flags,
    output data_out, level, empty, full,
    output overflow, underflow, interrupt
  );
endinterface

// File: rtl/mic_sample_fifo.sv
// Single-clock mic sample FIFO with synchronised capture strobe.
// Option MIC_FIFO_DROP_OLDEST_EN: overwrite oldest entry when full.
module mic_sample_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 128,
  parameter int IRQ_LEVEL   = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic              sys_clk,
  input logic              PRESETn,
  mic_sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [LW-1:0]          level_q, level_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   disarm_q, disarm_d;

  logic wr_pulse, full_w, empty_w;
  logic rd_ok, wr_ok, drop, adv_head;
  logic ovf_evt, unf_evt;

  assign wr_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign full_w   = (level_q == LW'(DEPTH));
  assign empty_w  = (level_q == '0);
  assign rd_ok    = bus.sync_read & ~empty_w;
  assign unf_evt  = bus.sync_read & empty_w;
  assign ovf_evt  = wr_pulse & full_w & ~bus.sync_read;

`ifdef MIC_FIFO_DROP_OLDEST_EN
  assign drop  = ovf_evt;
  assign wr_ok = wr_pulse;
`else
  assign drop  = 1'b0;
  assign wr_ok = wr_pulse & (~full_w | rd_ok);
`endif

  assign adv_head = rd_ok | drop;

  // next-state for pointers, level, flags and interrupt disarm
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    level_d  = level_q;
    disarm_d = disarm_q;
    if (adv_head) head_d = head_q + AW'(1);
    if (wr_ok)    tail_d = tail_q + AW'(1);
    if (wr_ok && !adv_head)      level_d = level_q + LW'(1);
    else if (adv_head && !wr_ok) level_d = level_q - LW'(1);
    if (rd_ok)                disarm_d = 1'b1;
    else if (bus.sync_enable) disarm_d = 1'b0;
    ovf_d = ovf_evt | (ovf_q & ~bus.clear_flags);
    unf_d = unf_evt | (unf_q & ~bus.clear_flags);
  end

  // control state with async reset; strobe synchroniser and edge flop
  always_ff @(posedge sys_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      head_q   <= '0;
      tail_q   <= '0;
      level_q  <= '0;
      sync_q   <= '0;
      dly_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      disarm_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      level_q  <= level_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.async_write};
      dly_q    <= sync_q[SYNC_STAGES-1];
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      disarm_q <= disarm_d;
    end
  end

  // sample storage, not reset; data_in captured on the commit edge
  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[tail_q] <= bus.data_in;
  end

  assign bus.data_out  = empty_w ? '0 : mem[head_q];
  assign bus.level     = level_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.interrupt = (level_q >= LW'(IRQ_LEVEL)) & ~disarm_q;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Bench for mic_sample_fifo: directed plan plus random traffic
// against a queue-based reference model.
module tb_mic_sample_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 128;
  localparam int IRQ   = 2;

  logic sys_clk = 1'b0;
  logic PRESETn = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mic_sample_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  mic_sample_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .IRQ_LEVEL(IRQ), .SYNC_STAGES(2)
  ) dut (
    .sys_clk(sys_clk),
    .PRESETn(PRESETn),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  string ph = "rst";

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            e;
    logic [DW-1:0] d;
  } pend_t;

  logic [DW-1:0] mq[$];
  pend_t         pq[$];
  bit            m_ovf, m_unf, m_dis, aw_prev;
  int            cyc = 0;

  task automatic m_reset();
    mq.delete();
    pq.delete();
    m_ovf   = 0;
    m_unf   = 0;
    m_dis   = 0;
    aw_prev = 0;
  endtask

  task automatic m_edge(input bit aw, input logic [DW-1:0] din,
                        input bit rd, input bit en, input bit cf);
    bit wr, full, emp, rok, oevt, uevt;
    logic [DW-1:0] wd;
    pend_t p;
    cyc++;
    if (!PRESETn) begin
      m_reset();
      return;
    end
    wr = 0;
    wd = '0;
    if (pq.size() > 0 && pq[0].e == cyc) begin
      wr = 1;
      wd = pq[0].d;
      void'(pq.pop_front());
    end
    full = (mq.size() == DEPTH);
    emp  = (mq.size() == 0);
    rok  = rd && !emp;
    uevt = rd && emp;
    oevt = wr && full && !rd;
    if (rok) void'(mq.pop_front());
    if (wr) begin
      if (oevt) begin
`ifdef MIC_FIFO_DROP_OLDEST_EN
        void'(mq.pop_front());
        mq.push_back(wd);
`endif
      end else begin
        mq.push_back(wd);
      end
    end
    if (rok)     m_dis = 1;
    else if (en) m_dis = 0;
    m_ovf = oevt || (m_ovf && !cf);
    m_unf = uevt || (m_unf && !cf);
    if (aw && !aw_prev) begin
      p.e = cyc + 2;
      p.d = din;
      pq.push_back(p);
    end
    aw_prev = aw;
  endtask

  task automatic m_check();
    int n;
    logic [DW-1:0] hd;
    n  = mq.size();
    hd = (n > 0) ? mq[0] : '0;
    chk({ph, ":level"}, 32'(bus.level), n);
    chk({ph, ":dout"}, 32'(bus.data_out), 32'(hd));
    chk({ph, ":empty"}, 32'(bus.empty), 32'(n == 0));
    chk({ph, ":full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({ph, ":ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({ph, ":unf"}, 32'(bus.underflow), 32'(m_unf));
    chk({ph, ":irq"}, 32'(bus.interrupt),
        32'((n >= IRQ) && !m_dis));
  endtask

  task automatic step(input bit aw, input logic [DW-1:0] din,
                      input bit rd, input bit en, input bit cf);
    @(negedge sys_clk);
    bus.async_write = aw;
    bus.data_in     = din;
    bus.sync_read   = rd;
    bus.sync_enable = en;
    bus.clear_flags = cf;
    @(posedge sys_clk);
    m_edge(aw, din, rd, en, cf);
    #1;
    m_check();
  endtask

  task automatic strobe(input logic [DW-1:0] d, input bit rd_commit);
    step(1, d, 0, 0, 0);
    step(0, d, 0, 0, 0);
    step(0, d, rd_commit, 0, 0);
  endtask

  task automatic drain_all();
    for (int k = 0; k < DEPTH + 4 && mq.size() > 0; k++)
      step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 1);
  endtask

  initial begin
    bit aw_cur;
    int hi_left, lo_left, rp;
    logic [DW-1:0] din_cur;
    int rtab[6] = '{0, 40, 5, 60, 20, 0};

    bus.async_write = 0;
    bus.data_in     = '0;
    bus.sync_read   = 0;
    bus.sync_enable = 0;
    bus.clear_flags = 0;
    m_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    m_check();
    chk("rst:empty", 32'(bus.empty), 1);
    @(negedge sys_clk);
    PRESETn = 1;

    ph = "wr3";
    strobe(16'hA001, 0);
    chk("wr3:lvl1", 32'(bus.level), 1);
    strobe(16'hA002, 0);
    chk("wr3:irq", 32'(bus.interrupt), 1);
    strobe(16'hA003, 0);
    chk("wr3:head", 32'(bus.data_out), 32'hA001);

    ph = "rd";
    step(0, '0, 1, 0, 0);
    chk("rd:d1", 32'(bus.data_out), 32'hA002);
    chk("rd:irq", 32'(bus.interrupt), 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("rd:empty", 32'(bus.empty), 1);
    step(0, '0, 1, 0, 0);
    chk("rd:unf", 32'(bus.underflow), 1);

    ph = "rearm";
    strobe(16'h0055, 0);
    strobe(16'h0066, 0);
    chk("rearm:irq0", 32'(bus.interrupt), 0);
    step(0, '0, 0, 1, 0);
    chk("rearm:irq1", 32'(bus.interrupt), 1);

    ph = "fill";
    drain_all();
    for (int i = 0; i < DEPTH; i++) strobe(DW'(i), 0);
    strobe(16'hBEEF, 0);
    chk("fill:full", 32'(bus.full), 1);
    chk("fill:ovf", 32'(bus.overflow), 1);
`ifdef MIC_FIFO_DROP_OLDEST_EN
    chk("fill:head", 32'(bus.data_out), 1);
`else
    chk("fill:head", 32'(bus.data_out), 0);
`endif
    for (int k = 0; k < DEPTH && mq.size() > 1; k++)
      step(0, '0, 1, 0, 0);
`ifdef MIC_FIFO_DROP_OLDEST_EN
    chk("fill:last", 32'(bus.data_out), 32'hBEEF);
`else
    chk("fill:last", 32'(bus.data_out), 127);
`endif
    drain_all();

    ph = "fullrd";
    for (int i = 0; i < DEPTH; i++) strobe(DW'(16'h1000 + i), 0);
    strobe(16'hC0DE, 1);
    chk("fullrd:lvl", 32'(bus.level), DEPTH);
    chk("fullrd:ovf", 32'(bus.overflow), 0);
    for (int k = 0; k < DEPTH && mq.size() > 1; k++)
      step(0, '0, 1, 0, 0);
    chk("fullrd:tail", 32'(bus.data_out), 32'hC0DE);
    drain_all();

    ph = "rand";
    aw_cur  = 0;
    hi_left = 0;
    lo_left = 2;
    din_cur = '0;
    for (int i = 0; i < 3000; i++) begin
      rp = rtab[i / 500];
      if (aw_cur) begin
        if (hi_left == 0) begin
          aw_cur  = 0;
          lo_left = $urandom_range(2, 5);
        end else hi_left--;
      end else if (lo_left == 0) begin
        aw_cur  = 1;
        din_cur = DW'($urandom);
        hi_left = $urandom_range(0, 2);
      end else lo_left--;
      step(aw_cur, din_cur,
           $urandom_range(0, 99) < rp,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0);
    end

    ph = "mrst";
    step(0, din_cur, 0, 0, 0);
    step(0, din_cur, 0, 0, 0);
    drain_all();
    for (int i = 0; i < 50; i++) strobe(DW'(16'h5000 + i), 0);
    chk("mrst:l50", 32'(bus.level), 50);
    step(1, 16'hDEAD, 0, 0, 0);
    @(negedge sys_clk);
    PRESETn = 0;
    bus.async_write = 0;
    #1;
    m_reset();
    m_check();
    chk("mrst:lvl0", 32'(bus.level), 0);
    repeat (2) step(0, '0, 0, 0, 0);
    @(negedge sys_clk);
    PRESETn = 1;
    repeat (10) step(0, '0, 0, 0, 0);
    chk("mrst:nostray", 32'(bus.level), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
